// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator unit: opcode encoding, FSM states and
// the default datapath width.
package acc_pkg;

  localparam int unsigned ACC_W = 8;

  typedef enum logic [2:0] {
    OpLda = 3'd0,
    OpAdd = 3'd1,
    OpSub = 3'd2,
    OpAnd = 3'd3,
    OpOr  = 3'd4,
    OpNot = 3'd5,
    OpMul = 3'd6,
    OpClr = 3'd7
  } acc_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } acc_state_e;

endpackage

// File: rtl/acc_addsub.sv
// N-bit combinational ripple adder/subtractor: S = A + (D ? ~B : B) + D, Cout = carry-out.
module acc_addsub #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         D,
  output logic [N-1:0] S,
  output logic         Cout
);

  always_comb begin
    logic c;
    logic bx;
    c = D;
    S = '0;
    for (int i = 0; i < int'(N); i++) begin
      bx   = B[i] ^ D;
      S[i] = A[i] ^ bx ^ c;
      c    = (A[i] & bx) | (c & (A[i] ^ bx));
    end
    Cout = c;
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator unit with single-cycle ALU ops and an N-cycle shift-add multiplier.
// Defining ACC_UNIT_OVF_FLAG_EN adds the flag_v signed-overflow output for ADD/SUB.
module acc_unit
  import acc_pkg::*;
#(
  parameter int unsigned N = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] operand,
  output logic [N-1:0] acc,
  output logic         res_valid,
  output logic         flag_n,
  output logic         flag_z,
`ifdef ACC_UNIT_OVF_FLAG_EN
  output logic         flag_c,
  output logic         flag_v
`else
  output logic         flag_c
`endif
);

  localparam int unsigned CntW = $clog2(N);

  acc_state_e    state_q;
  logic [N-1:0]  hi_q, lo_q, mcand_q;
  logic [CntW-1:0] cnt_q;

  acc_op_e       op_e;
  logic [N-1:0]  add_a, add_b, sum;
  logic          add_d, cout;
  logic [N-1:0]  hi_n, lo_n;
  logic [N-1:0]  res;
  logic          res_c;
  logic          accept, mul_last;

  assign op_e     = acc_op_e'(op);
  assign op_ready = (state_q == StIdle) && !rst;
  assign accept   = op_valid && op_ready;
  assign mul_last = (state_q == StMul) && (cnt_q == CntW'(N - 1));

  // The adder serves ADD/SUB in IDLE and the partial-product accumulation in MUL.
  always_comb begin
    add_a = acc;
    add_b = operand;
    add_d = (op_e == OpSub);
    if (state_q == StMul) begin
      add_a = hi_q;
      add_b = mcand_q;
      add_d = 1'b0;
    end
  end

  acc_addsub #(.N(N)) u_addsub (
    .A    (add_a),
    .B    (add_b),
    .D    (add_d),
    .S    (sum),
    .Cout (cout)
  );

  // One shift-add step over the {hi, lo} product register.
  always_comb begin
    if (lo_q[0]) {hi_n, lo_n} = {cout, sum, lo_q[N-1:1]};
    else         {hi_n, lo_n} = {1'b0, hi_q, lo_q[N-1:1]};
  end

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (op_e)
      OpLda: res = operand;
      OpAdd, OpSub: begin
        res   = sum;
        res_c = cout;
      end
      OpAnd: res = acc & operand;
      OpOr:  res = acc | operand;
      OpNot: res = ~acc;
      OpMul: res = acc;
      OpClr: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc       <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b1;
      flag_c    <= 1'b0;
      res_valid <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (op_e == OpMul) begin
              mcand_q <= acc;
              lo_q    <= operand;
              hi_q    <= '0;
              cnt_q   <= '0;
              state_q <= StMul;
            end else begin
              acc       <= res;
              flag_n    <= res[N-1];
              flag_z    <= (res == '0);
              flag_c    <= res_c;
              res_valid <= 1'b1;
            end
          end
        end
        StMul: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (mul_last) begin
            acc       <= lo_n;
            flag_n    <= lo_n[N-1];
            flag_z    <= (lo_n == '0);
            flag_c    <= (hi_n != '0);
            res_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ACC_UNIT_OVF_FLAG_EN
  logic [N-1:0] b_eff;
  logic         res_v;

  assign b_eff = add_d ? ~operand : operand;
  assign res_v = ((op_e == OpAdd) || (op_e == OpSub)) && (acc[N-1] == b_eff[N-1]) &&
                 (sum[N-1] != acc[N-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_v <= 1'b0;
    end else if (accept && (op_e != OpMul)) begin
      flag_v <= res_v;
    end else if (mul_last) begin
      flag_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_acc_unit.sv
// Directed self-checking bench for acc_unit (N=8) with hand-computed expected values.
module tb_acc_unit;
  import acc_pkg::*;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op;
  logic [N-1:0] operand;
  logic [N-1:0] acc;
  logic         res_valid;
  logic         flag_n, flag_z, flag_c;
`ifdef ACC_UNIT_OVF_FLAG_EN
  logic         flag_v;
`endif

  int n_checks = 0;
  int n_errors = 0;

  acc_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .operand   (operand),
    .acc       (acc),
    .res_valid (res_valid),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
`ifdef ACC_UNIT_OVF_FLAG_EN
    .flag_c    (flag_c),
    .flag_v    (flag_v)
`else
    .flag_c    (flag_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input acc_op_e o, input logic [N-1:0] d);
    op_valid = 1'b1;
    op       = o;
    operand  = d;
    cyc();
    op_valid = 1'b0;
  endtask

  initial begin
    int low_cnt;
    int rv_cnt;
    logic [N-1:0] mul_acc;
    logic mul_c;

    rst = 1'b1;
    op_valid = 1'b0;
    op = OpLda;
    operand = '0;

    // Reset held two cycles
    cyc();
    check("ready_in_rst1", op_ready, 0);
    cyc();
    check("ready_in_rst2", op_ready, 0);
    check("rst_acc", acc, 8'h00);
    check("rst_z", flag_z, 1);
    check("rst_c", flag_c, 0);
    check("rst_rv", res_valid, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", op_ready, 1);

    // LDA 0xFF, ADD 0x01 back-to-back
    op_valid = 1'b1;
    op = OpLda;
    operand = 8'hFF;
    cyc();
    check("lda_ff_acc", acc, 8'hFF);
    check("lda_ff_rv", res_valid, 1);
    check("lda_ff_ready", op_ready, 1);
    op = OpAdd;
    operand = 8'h01;
    cyc();
    op_valid = 1'b0;
    check("add_wrap_acc", acc, 8'h00);
    check("add_wrap_z", flag_z, 1);
    check("add_wrap_c", flag_c, 1);
    check("add_wrap_rv", res_valid, 1);
    cyc();
    check("idle_rv", res_valid, 0);

    // SUB borrow and no-borrow
    issue(OpLda, 8'h00);
    issue(OpSub, 8'h01);
    check("sub_borrow_acc", acc, 8'hFF);
    check("sub_borrow_n", flag_n, 1);
    check("sub_borrow_c", flag_c, 0);
    issue(OpLda, 8'h0F);
    issue(OpSub, 8'h07);
    check("sub_acc", acc, 8'h08);
    check("sub_c", flag_c, 1);
    check("sub_n", flag_n, 0);

    // Logic ops
    issue(OpLda, 8'hF0);
    issue(OpAnd, 8'h3C);
    check("and_acc", acc, 8'h30);
    issue(OpOr, 8'h05);
    check("or_acc", acc, 8'h35);
    issue(OpNot, 8'h00);
    check("not_acc", acc, 8'hCA);
    check("not_n", flag_n, 1);
    issue(OpClr, 8'h77);
    check("clr_acc", acc, 8'h00);
    check("clr_z", flag_z, 1);
    check("clr_c", flag_c, 0);

    // MUL 0x10 * 0x11 = 0x110 with an ignored request mid-way
    issue(OpLda, 8'h10);
    issue(OpMul, 8'h11);
    low_cnt = 0;
    rv_cnt = 0;
    mul_acc = '0;
    mul_c = 1'b0;
    for (int i = 0; i < 20 && !op_ready; i++) begin
      low_cnt++;
      if (res_valid) begin
        rv_cnt++;
        mul_acc = acc;
        mul_c = flag_c;
      end
      op_valid = (i == 3);
      op = OpLda;
      operand = 8'h55;
      cyc();
    end
    op_valid = 1'b0;
    check("mul_busy_cycles", low_cnt, 9);
    check("mul_rv_pulses", rv_cnt, 1);
    check("mul_acc", mul_acc, 8'h10);
    check("mul_c", mul_c, 1);
    check("mul_ignored_acc", acc, 8'h10);
    check("mul_after_rv", res_valid, 0);

    // MUL 0x0F * 0x0E = 0xD2, no upper bits
    issue(OpLda, 8'h0F);
    issue(OpMul, 8'h0E);
    for (int i = 0; i < 20 && !res_valid; i++) cyc();
    check("mul2_rv", res_valid, 1);
    check("mul2_acc", acc, 8'hD2);
    check("mul2_c", flag_c, 0);
    check("mul2_n", flag_n, 1);
    cyc();
    cyc();

    // Reset in cycle 4 of a MUL
    issue(OpLda, 8'h03);
    issue(OpMul, 8'h05);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("abort_ready_rst", op_ready, 0);
    cyc();
    rst = 1'b0;
    check("abort_acc", acc, 8'h00);
    check("abort_z", flag_z, 1);
    check("abort_rv", res_valid, 0);
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) rv_cnt++;
      cyc();
    end
    check("abort_no_pulse", rv_cnt, 0);
    check("abort_ready", op_ready, 1);
    issue(OpLda, 8'h42);
    check("post_abort_acc", acc, 8'h42);
    check("post_abort_rv", res_valid, 1);

`ifdef ACC_UNIT_OVF_FLAG_EN
    issue(OpLda, 8'h7F);
    issue(OpAdd, 8'h01);
    check("ovf_acc", acc, 8'h80);
    check("ovf_v", flag_v, 1);
    check("ovf_n", flag_n, 1);
    issue(OpAnd, 8'hFF);
    check("ovf_clear_v", flag_v, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
